// File: rtl/rd_fifo_status_ctrl_pkg.sv
// State encoding, timeout default and burst sizing helper shared by the VDMA FIFO controllers.
package rd_fifo_status_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEED_RD,
    ST_WAIT_DONE,
    ST_FSH,
    ST_FRAME_END,
    ST_TIME_ERR,
    ST_RESET_CHAIN
  } state_t;

  localparam logic [23:0] DEF_TIMEOUT_CYC = 24'hFFF000;

  function automatic int unsigned clip_len(input int unsigned remain, input int unsigned burst);
    return (remain < burst) ? remain : burst;
  endfunction

endpackage

// File: rtl/fifo_ctrl_watchdog.sv
// Burst watchdog: counts cycles while a burst is outstanding and flags when LIMIT is exceeded.
// Only built when RD_FIFO_TIMEOUT_EN is defined; expired is a combinational compare of the count.
`ifdef RD_FIFO_TIMEOUT_EN
module fifo_ctrl_watchdog #(
  parameter logic [23:0] LIMIT = 24'hFFF000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [23:0] cyc_cnt;

  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      cyc_cnt <= '0;
    end else if (run && !expired) begin
      cyc_cnt <= cyc_cnt + 24'd1;
    end
  end

  assign expired = (cyc_cnt > LIMIT);

endmodule
`endif

// File: rtl/rd_fifo_status_ctrl.sv
// Read-FIFO status controller: requests AXI read bursts when they fit, tracks line/frame progress.
// burst_req follows room_ok by 1 cycle (count change by 2); RD_FIFO_TIMEOUT_EN adds a burst watchdog.
module rd_fifo_status_ctrl
  import rd_fifo_status_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 512,
  parameter int          CSIZE       = 10,
  parameter int          BURST_LEN   = 100,
  parameter int          LSIZE       = 9,
  parameter int          WSIZE       = 16,
  parameter logic [23:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             f_rst_status,
  input  logic [WSIZE-1:0] hsize,
  input  logic [15:0]      vsize,
  input  logic [CSIZE-1:0] count,
  input  logic             fifo_empty,
  output logic             burst_req,
  output logic [LSIZE-1:0] req_len,
  input  logic             resp,
  input  logic             done,
  output logic             burst_done,
  output logic             line_done,
  output logic             frame_done,
  output logic             busy,
  output logic             rst_chain
);

  localparam logic [CSIZE:0] DEPTH_EXT = (CSIZE+1)'(FIFO_DEPTH);

  state_t           state, nstate;
  logic [WSIZE-1:0] remain, hsize_r;
  logic [15:0]      line_cnt, vsize_r;
  logic [LSIZE-1:0] next_len;
  logic [CSIZE:0]   count_ext, free_words;
  logic             room_ok, room_calc, line_end, frame_end, timeout;

  assign next_len   = LSIZE'(clip_len(32'(remain), BURST_LEN));
  assign count_ext  = {1'b0, count};
  assign free_words = (count_ext >= DEPTH_EXT) ? '0 : DEPTH_EXT - count_ext;
  assign room_calc  = (32'(free_words) >= 32'(next_len)) && (remain != '0);
  assign line_end   = (remain == WSIZE'(req_len));
  assign frame_end  = line_end && (({1'b0, line_cnt} + 17'd1) == {1'b0, vsize_r});

  always_ff @(posedge clock) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (f_rst_status) begin
      nstate = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (enable && room_ok && (remain != '0) && (vsize_r != '0)) nstate = ST_NEED_RD;
        ST_NEED_RD:
          if (timeout)          nstate = ST_TIME_ERR;
          else if (resp && done) nstate = ST_FSH;
          else if (resp)         nstate = ST_WAIT_DONE;
        ST_WAIT_DONE:
          if (timeout)   nstate = ST_TIME_ERR;
          else if (done) nstate = ST_FSH;
        ST_FSH:         nstate = frame_end ? ST_FRAME_END : ST_IDLE;
        ST_FRAME_END:   nstate = ST_FRAME_END;
        ST_TIME_ERR:    nstate = ST_RESET_CHAIN;
        ST_RESET_CHAIN: if (fifo_empty) nstate = ST_IDLE;
        default:        nstate = ST_IDLE;
      endcase
    end
  end

  // room_ok is only evaluated while settled in IDLE so a stale remain never sizes a request
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      remain     <= '0;
      hsize_r    <= '0;
      line_cnt   <= '0;
      vsize_r    <= '0;
      req_len    <= '0;
      room_ok    <= 1'b0;
      burst_req  <= 1'b0;
      burst_done <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      room_ok    <= !f_rst_status && (state == ST_IDLE) && room_calc;
      burst_req  <= (nstate == ST_NEED_RD);
      burst_done <= (nstate == ST_FSH);
      line_done  <= (nstate == ST_FSH) && line_end;
      frame_done <= (nstate == ST_FSH) && frame_end;
      busy       <= (nstate != ST_IDLE) && (nstate != ST_FRAME_END);
      if (f_rst_status) begin
        remain   <= hsize;
        hsize_r  <= hsize;
        line_cnt <= '0;
        vsize_r  <= vsize;
      end else begin
        case (state)
          ST_IDLE:
            if (nstate == ST_NEED_RD) req_len <= next_len;
          ST_FSH:
            if (line_end) begin
              remain   <= hsize_r;
              line_cnt <= line_cnt + 16'd1;
            end else begin
              remain <= remain - WSIZE'(req_len);
            end
          ST_RESET_CHAIN:
            if (fifo_empty) remain <= hsize_r;
          default: ;
        endcase
      end
    end
  end

`ifdef RD_FIFO_TIMEOUT_EN
  logic wd_run, wd_clear;

  assign wd_run   = (state == ST_NEED_RD) || (state == ST_WAIT_DONE);
  assign wd_clear = (state == ST_IDLE);

  fifo_ctrl_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (timeout)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) rst_chain <= 1'b0;
    else        rst_chain <= (nstate == ST_TIME_ERR);
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign rst_chain          = 1'b0;
`endif

endmodule

// File: tb/tb_rd_fifo_status_ctrl.sv
// Bench for rd_fifo_status_ctrl: directed scenarios plus randomized frames scored against a burst-list model.
`timescale 1ns/1ps
module tb_rd_fifo_status_ctrl;

  localparam int DEPTH = 512;
  localparam int BURST = 100;
  localparam int CSIZE = 10;
  localparam int LSIZE = 9;
  localparam int WSIZE = 16;

  logic             clock = 1'b0;
  logic             rst_n, enable, f_rst_status, fifo_empty, resp, done;
  logic [WSIZE-1:0] hsize;
  logic [15:0]      vsize;
  logic [CSIZE-1:0] count;
  logic             burst_req, burst_done, line_done, frame_done, busy, rst_chain;
  logic [LSIZE-1:0] req_len;

  always #5 clock = ~clock;

  rd_fifo_status_ctrl #(
    .FIFO_DEPTH (DEPTH), .CSIZE (CSIZE), .BURST_LEN (BURST),
    .LSIZE (LSIZE), .WSIZE (WSIZE), .TIMEOUT_CYC (24'd64)
  ) dut (
    .clock (clock), .rst_n (rst_n), .enable (enable), .f_rst_status (f_rst_status),
    .hsize (hsize), .vsize (vsize), .count (count), .fifo_empty (fifo_empty),
    .burst_req (burst_req), .req_len (req_len), .resp (resp), .done (done),
    .burst_done (burst_done), .line_done (line_done), .frame_done (frame_done),
    .busy (busy), .rst_chain (rst_chain)
  );

  typedef struct {
    int len;
    bit le;
    bit fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0, eng_on = 0, eng_rand = 0, rnd_cnt = 0, frame_seen = 0;
  int   eng_phase = 0, eng_dly = 0, burst_cnt = 0, cnt_prev = 0;
  logic prev_req = 1'b0;

  // Expected burst list: each line is cut into BURST-sized pieces with the remainder last.
  task automatic build_frame(input int h, input int v);
    exp_q.delete();
    for (int l = 0; l < v; l++) begin
      int rem = h;
      while (rem > 0) begin
        int len = (rem < BURST) ? rem : BURST;
        rem -= len;
        exp_q.push_back('{len, rem == 0, (rem == 0) && (l == v - 1)});
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (mon_on) begin
      if (burst_req === 1'b1 && prev_req !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: req_len %0d, no burst expected", req_len);
        end else if (req_len !== LSIZE'(exp_q[0].len)) begin
          errors++;
          $display("FAIL req_len: got %0d expected %0d", req_len, exp_q[0].len);
        end
        checks++;
        if (DEPTH - cnt_prev < int'(req_len)) begin
          errors++;
          $display("FAIL room: req_len %0d with count %0d exceeds free space", req_len, cnt_prev);
        end
      end
      checks++;
      if (burst_done === 1'b1) begin
        burst_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL burst_extra: burst_done with no burst expected");
        end else begin
          e = exp_q.pop_front();
          if ({req_len, line_done, frame_done} !== {LSIZE'(e.len), e.le, e.fe}) begin
            errors++;
            $display("FAIL burst_flags: got len %0d line %b frame %b expected len %0d line %b frame %b",
                     req_len, line_done, frame_done, e.len, e.le, e.fe);
          end
          if (e.fe) frame_seen = 1;
        end
      end else if ({line_done, frame_done} !== 2'b00) begin
        errors++;
        $display("FAIL flag_alone: line %b frame %b without burst_done", line_done, frame_done);
      end
    end
    cnt_prev = int'(count);
    prev_req = burst_req;
    if (eng_on) begin
      resp = 1'b0;
      done = 1'b0;
      if (eng_phase == 0 && burst_req === 1'b1) begin
        eng_phase = 1;
        eng_dly   = eng_rand ? $urandom_range(0, 3) : 0;
      end
      if (eng_phase == 1) begin
        if (eng_dly == 0) begin
          resp = 1'b1;
          if (!eng_rand || $urandom_range(0, 3) == 0) begin
            done      = 1'b1;
            eng_phase = 0;
          end else begin
            eng_phase = 2;
            eng_dly   = $urandom_range(0, 5);
          end
        end else eng_dly--;
      end else if (eng_phase == 2) begin
        if (eng_dly == 0) begin
          done      = 1'b1;
          eng_phase = 0;
        end else eng_dly--;
      end
    end
    if (rnd_cnt) begin
      if ($urandom_range(0, 7) == 0)
        count = ($urandom_range(0, 3) == 0) ? CSIZE'($urandom_range(400, 512)) : CSIZE'($urandom_range(0, 400));
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic start_frame(input int h, input int v);
    hsize        = WSIZE'(h);
    vsize        = 16'(v);
    f_rst_status = 1'b1;
    tick();
    f_rst_status = 1'b0;
  endtask

  task automatic wait_req(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (burst_req === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_frame(input int h, input int v, input bit rnd);
    bit seen = 0;
    count = '0; enable = 1'b1; resp = 1'b0; done = 1'b0;
    start_frame(h, v);
    build_frame(h, v);
    burst_cnt = 0; frame_seen = 0; eng_phase = 0;
    eng_rand = rnd; rnd_cnt = rnd; mon_on = 1; eng_on = 1;
    for (int i = 0; i < 20000 && !frame_seen; i++) tick();
    checks++;
    if (!frame_seen) begin
      errors++;
      $display("FAIL frame_timeout: hsize %0d vsize %0d, %0d bursts left", h, v, exp_q.size());
    end
    eng_on = 0; rnd_cnt = 0; resp = 1'b0; done = 1'b0; count = '0; enable = 1'b1;
    repeat (10) begin
      tick();
      if (burst_req !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_end_idle: activity %b, %0d bursts left", seen, exp_q.size());
    end
    mon_on = 0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst_n = 1'b0; enable = 1'b0; f_rst_status = 1'b0; hsize = '0; vsize = '0;
    count = '0; fifo_empty = 1'b1; resp = 1'b0; done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({burst_req, burst_done, line_done, frame_done, busy, rst_chain} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {burst_req, burst_done, line_done, frame_done, busy, rst_chain});
    end
    checks++;
    if (req_len !== '0) begin
      errors++;
      $display("FAIL reset_req_len: got %0d expected 0", req_len);
    end
    rst_n = 1'b1; enable = 1'b1;
    repeat (20) begin
      tick();
      if (burst_req !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_idle: activity 1 expected 0");
    end
  endtask

  task automatic test_frame_basic();
    run_frame(250, 2, 0);
    checks++;
    if (burst_cnt !== 6) begin
      errors++;
      $display("FAIL basic_burst_count: got %0d expected 6", burst_cnt);
    end
  endtask

  task automatic test_room();
    bit seen = 0;
    eng_on = 0; enable = 1'b1; resp = 1'b0; done = 1'b0;
    count = CSIZE'(512);
    start_frame(250, 2);
    repeat (10) begin tick(); if (burst_req !== 1'b0) seen = 1; end
    count = CSIZE'(420);
    repeat (20) begin tick(); if (burst_req !== 1'b0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL room_full: burst_req 1 expected 0"); end
    count = CSIZE'(412);
    tick();
    checks++;
    if (burst_req !== 1'b0) begin errors++; $display("FAIL room_lat1: burst_req %b expected 0", burst_req); end
    tick();
    checks++;
    if (burst_req !== 1'b1 || req_len !== LSIZE'(100)) begin
      errors++;
      $display("FAIL room_lat2: burst_req %b len %0d expected 1 len 100", burst_req, req_len);
    end
    resp = 1'b1; done = 1'b1;
    tick();
    resp = 1'b0; done = 1'b0;
    checks++;
    if ({burst_done, burst_req} !== 2'b10) begin
      errors++;
      $display("FAIL same_cycle: burst_done,burst_req %b expected 10", {burst_done, burst_req});
    end
    tick();
    checks++;
    if ({burst_done, line_done} !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_pulse: burst_done,line_done %b expected 00", {burst_done, line_done});
    end
  endtask

  task automatic test_frst_wait();
    bit ok;
    eng_on = 0; count = '0; enable = 1'b1; resp = 1'b0; done = 1'b0;
    start_frame(150, 1);
    wait_req(50, ok);
    resp = 1'b1; done = 1'b1;
    tick();
    resp = 1'b0; done = 1'b0;
    wait_req(50, ok);
    checks++;
    if (!ok || req_len !== LSIZE'(50)) begin
      errors++;
      $display("FAIL frst_second_len: req %b len %0d expected 1 len 50", ok, req_len);
    end
    resp = 1'b1;
    tick();
    resp = 1'b0;
    checks++;
    if ({busy, burst_req} !== 2'b10) begin
      errors++;
      $display("FAIL frst_wait_state: busy,burst_req %b expected 10", {busy, burst_req});
    end
    f_rst_status = 1'b1;
    tick();
    f_rst_status = 1'b0;
    checks++;
    if ({busy, burst_req} !== 2'b00) begin
      errors++;
      $display("FAIL frst_idle: busy,burst_req %b expected 00", {busy, burst_req});
    end
    wait_req(50, ok);
    checks++;
    if (!ok || req_len !== LSIZE'(100)) begin
      errors++;
      $display("FAIL frst_reload_len: req %b len %0d expected 1 len 100", ok, req_len);
    end
  endtask

  task automatic test_enable();
    bit ok;
    bit seen = 0;
    eng_on = 0; count = '0; enable = 1'b1; resp = 1'b0; done = 1'b0;
    start_frame(300, 1);
    wait_req(50, ok);
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (!ok || {burst_req, burst_done} !== 2'b10) begin
      errors++;
      $display("FAIL done_ignored: burst_req,burst_done %b expected 10", {burst_req, burst_done});
    end
    resp = 1'b1;
    tick();
    resp = 1'b0; enable = 1'b0;
    tick();
    checks++;
    if ({busy, burst_req} !== 2'b10) begin
      errors++;
      $display("FAIL en_wait_state: busy,burst_req %b expected 10", {busy, burst_req});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (burst_done !== 1'b1) begin
      errors++;
      $display("FAIL en_burst_completes: burst_done %b expected 1", burst_done);
    end
    repeat (20) begin tick(); if (burst_req !== 1'b0) seen = 1; end
    checks++;
    if (seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: req seen %b busy %b expected 0 0", seen, busy);
    end
    enable = 1'b1;
    wait_req(10, ok);
    checks++;
    if (!ok || req_len !== LSIZE'(100)) begin
      errors++;
      $display("FAIL en_resume: req %b len %0d expected 1 len 100", ok, req_len);
    end
  endtask

  task automatic test_zero_size();
    for (int k = 0; k < 2; k++) begin
      bit seen = 0;
      eng_on = 0; count = '0; enable = 1'b1; resp = 1'b0; done = 1'b0;
      if (k == 0) start_frame(0, 2);
      else        start_frame(100, 0);
      repeat (30) begin
        tick();
        if (burst_req !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL zero_size_%0d: activity 1 expected 0", k);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int pulses = 0;
    eng_on = 0; count = '0; enable = 1'b1; resp = 1'b0; done = 1'b0; fifo_empty = 1'b0;
    start_frame(250, 1);
    wait_req(50, ok);
    resp = 1'b1;
    tick();
    resp = 1'b0;
    repeat (200) begin
      tick();
      if (rst_chain === 1'b1) pulses++;
    end
`ifdef RD_FIFO_TIMEOUT_EN
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL to_chain_wait: busy %b expected 1", busy); end
    fifo_empty = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_chain_idle: busy %b expected 0", busy); end
    wait_req(20, ok);
    checks++;
    if (!ok || req_len !== LSIZE'(100)) begin
      errors++;
      $display("FAIL to_restart: req %b len %0d expected 1 len 100", ok, req_len);
    end
`else
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL to_pulses: got %0d expected 0", pulses); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL to_stall: busy %b expected 1", busy); end
`endif
    fifo_empty = 1'b1;
    start_frame(0, 0);
  endtask

  task automatic test_random_frames();
    run_frame(100, 1, 1);
    run_frame(37, 3, 1);
    run_frame(400, 2, 1);
    for (int i = 0; i < 5; i++)
      run_frame($urandom_range(1, 420), $urandom_range(1, 3), 1);
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_room();
    test_frst_wait();
    test_enable();
    test_zero_size();
    test_timeout();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL sim_timeout: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule
